l2_cache_assoc: RTL and testbench

L2_CACHE_ASSOC -- requirements
Module: l2_cache_assoc

---
 rtl/l2_cache_assoc_pkg.sv | 14 +
 rtl/l2_cache_assoc_if.sv | 32 +++
 rtl/l2_cache_assoc_lru.sv | 43 ++++
 rtl/l2_cache_assoc.sv | 139 +++++++++++++
 tb/tb_l2_cache_assoc.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/l2_cache_assoc_pkg.sv
// l2_pkg: shared FSM state, line metadata and default geometry for the L2 cache
package l2_pkg;
  localparam int L2_ADDR_W = 32;
  localparam int L2_LINE_W = 128;
  localparam int L2_SETS = 512;
  localparam int L2_WAYS = 4;
  localparam int L2_TAG_W = L2_ADDR_W - $clog2(L2_SETS) - $clog2(L2_LINE_W / 8);
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} l2_state_t;
  typedef struct packed {
    logic [L2_TAG_W-1:0] tag;
    logic valid;
    logic dirty;
  } l2_meta_t;
endpackage

// File: rtl/l2_cache_assoc_if.sv
// l2_cache_assoc_if: CCU request/response and memory-side bus of the L2 cache
interface l2_cache_assoc_if import l2_pkg::*; #(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int LINE_W = L2_LINE_W
);
  logic req_valid;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic ready;
  logic [LINE_W-1:0] read_data;
  logic l2_hit;
  logic l2_miss;
  logic mem_read_req;
  logic mem_write_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_write_data;
  logic [LINE_W-1:0] mem_read_data;
  logic mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    input ready, read_data, l2_hit, l2_miss, mem_read_req, mem_write_req, mem_addr,
    input mem_write_data, hit_count, miss_count
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    output ready, read_data, l2_hit, l2_miss, mem_read_req, mem_write_req, mem_addr,
    output mem_write_data, hit_count, miss_count
  );
endinterface

// File: rtl/l2_cache_assoc_lru.sv
// l2_lru: per-set true-LRU ages (0 = MRU, WAYS-1 = LRU), victim is the oldest way
module l2_lru import l2_pkg::*; #(
  parameter int SETS = L2_SETS,
  parameter int WAYS = L2_WAYS,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [IDX_W-1:0] set,
  input  logic [WAY_W-1:0] way,
  input  logic touch,
  output logic [WAY_W-1:0] victim
);
  generate
    if (WAYS == 1) begin : g_dm
      logic unused_ok;
      assign unused_ok = ^{clk, rst, set, way, touch};
      assign victim = '0;
    end else begin : g_lru
      localparam int AGE_W = $clog2(WAYS);
      logic [AGE_W-1:0] age [SETS][WAYS];
      // victim is the way whose age has reached the maximum
      always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++)
          if (age[set][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
      end
      // touched way becomes MRU, every younger way ages by one; reset leaves way0 oldest
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age[s][w] <= AGE_W'(WAYS - 1 - w);
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++)
            if (WAY_W'(w) == way) age[set][w] <= '0;
            else if (age[set][w] < age[set][way]) age[set][w] <= age[set][w] + 1'b1;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc: set-associative write-back L2 with LRU replacement and perf counters
module l2_cache_assoc import l2_pkg::*; #(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int LINE_W = L2_LINE_W,
  parameter int SETS = L2_SETS,
  parameter int WAYS = L2_WAYS
) (
  input logic clk,
  input logic rst,
  l2_cache_assoc_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  l2_state_t state;
  logic wr_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [LINE_W-1:0] wdata_q, line_q, dat_wdata;
  logic [WAY_W-1:0] vic_q, hit_way, inv_way, lru_vic, vic, upd_way;
  logic hit, any_inv, upd, dat_we;
  logic [31:0] hit_q, miss_q;
  l2_meta_t meta [SETS][WAYS];
  logic [LINE_W-1:0] data [SETS][WAYS];
  logic unused_ok;
  assign unused_ok = ^bus.req_addr[OFF_W-1:0];
  assign bus.hit_count = hit_q;
  assign bus.miss_count = miss_q;
  // tag match and lowest-index invalid way for the latched set
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (meta[idx_q][w].valid && meta[idx_q][w].tag == L2_TAG_W'(tag_q)) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!meta[idx_q][w].valid) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end
  assign vic = any_inv ? inv_way : lru_vic;
  assign upd = (state == LOOKUP && hit) || (state == FILL && bus.mem_ready);
  assign upd_way = (state == FILL) ? vic_q : hit_way;
  assign dat_we = upd && (state == FILL || wr_q);
  assign dat_wdata = (state == FILL && !wr_q) ? bus.mem_read_data : wdata_q;
  l2_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk(clk), .rst(rst), .set(idx_q), .way(upd_way), .touch(upd), .victim(lru_vic)
  );
  // line storage is not reset; the FSM resets to IDLE so no write can land during reset
  always_ff @(posedge clk)
    if (dat_we) data[idx_q][upd_way] <= dat_wdata;
  // request FSM: metadata, memory handshake, counters and all bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wr_q <= 1'b0;
      tag_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      vic_q <= '0;
      line_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
      bus.ready <= 1'b0;
      bus.read_data <= '0;
      bus.l2_hit <= 1'b0;
      bus.l2_miss <= 1'b0;
      bus.mem_read_req <= 1'b0;
      bus.mem_write_req <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_write_data <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          meta[s][w] <= '0;
    end else begin
      bus.ready <= 1'b0;
      bus.l2_hit <= 1'b0;
      bus.l2_miss <= 1'b0;
      case (state)
        IDLE:
          if (bus.req_valid && !bus.ready) begin
            wr_q <= bus.req_write;
            tag_q <= bus.req_addr[ADDR_W-1 -: TAG_W];
            idx_q <= bus.req_addr[OFF_W +: IDX_W];
            wdata_q <= bus.req_wdata;
            state <= LOOKUP;
          end
        LOOKUP:
          if (hit) begin
            bus.l2_hit <= 1'b1;
            if (hit_q != '1) hit_q <= hit_q + 32'd1;
            line_q <= data[idx_q][hit_way];
            if (wr_q) meta[idx_q][hit_way].dirty <= 1'b1;
            state <= RESPOND;
          end else begin
            bus.l2_miss <= 1'b1;
            if (miss_q != '1) miss_q <= miss_q + 32'd1;
            vic_q <= vic;
            if (meta[idx_q][vic].valid && meta[idx_q][vic].dirty) begin
              bus.mem_write_req <= 1'b1;
              bus.mem_addr <= {TAG_W'(meta[idx_q][vic].tag), idx_q, {OFF_W{1'b0}}};
              bus.mem_write_data <= data[idx_q][vic];
              state <= WRITEBACK;
            end else begin
              bus.mem_read_req <= 1'b1;
              bus.mem_addr <= {tag_q, idx_q, {OFF_W{1'b0}}};
              state <= FILL;
            end
          end
        WRITEBACK:
          if (bus.mem_ready) begin
            bus.mem_write_req <= 1'b0;
            bus.mem_read_req <= 1'b1;
            bus.mem_addr <= {tag_q, idx_q, {OFF_W{1'b0}}};
            state <= FILL;
          end
        FILL:
          if (bus.mem_ready) begin
            bus.mem_read_req <= 1'b0;
            meta[idx_q][vic_q] <= '{tag: L2_TAG_W'(tag_q), valid: 1'b1, dirty: wr_q};
            line_q <= bus.mem_read_data;
            state <= RESPOND;
          end
        RESPOND: begin
          bus.ready <= 1'b1;
          if (!wr_q) bus.read_data <= line_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb_l2_cache_assoc: directed hit/miss/writeback/LRU/reset/saturation checks for l2_cache_assoc
module tb_l2_cache_assoc;
  import l2_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int hits = 0;
  int misses = 0;
  localparam logic [31:0] A = 32'h0000_1230;
  localparam logic [31:0] B = 32'h0000_3230;
  localparam logic [31:0] C = 32'h0000_5230;
  localparam logic [31:0] D = 32'h0000_7230;
  localparam logic [31:0] E = 32'h0000_9230;
  localparam logic [31:0] F = 32'h0000_B230;
  localparam logic [31:0] G = 32'h0000_D230;
  localparam logic [31:0] H = 32'h0000_F230;
  localparam logic [127:0] A5 = {16{8'hA5}};
  always #5 clk = ~clk;
  l2_cache_assoc_if bus ();
  l2_cache_assoc dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one request: act as CCU and memory, checking lookup result, memory traffic and response
  task automatic access(input string nm, input logic wr, input logic [31:0] a, input logic [127:0] wd,
                        input logic exp_hit, input logic exp_wb, input logic [31:0] wb_a,
                        input logic [127:0] wb_d, input logic [127:0] fill, input logic [127:0] exp_rd);
    int cyc;
    bit done;
    bit wb_seen;
    cyc = 0;
    done = 0;
    wb_seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr = a;
    bus.req_wdata = wd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_ready = 1'b0;
      if (cyc == 2) begin
        check({nm, ".hit"}, bus.l2_hit, exp_hit);
        check({nm, ".miss"}, bus.l2_miss, !exp_hit);
      end
      if (bus.mem_write_req) begin
        wb_seen = 1;
        check({nm, ".wb_addr"}, bus.mem_addr, wb_a);
        check({nm, ".wb_data"}, bus.mem_write_data, wb_d);
        check({nm, ".wb_excl"}, bus.mem_read_req, 0);
        bus.mem_ready = 1'b1;
      end else if (bus.mem_read_req) begin
        check({nm, ".fill_addr"}, bus.mem_addr, {a[31:4], 4'h0});
        bus.mem_read_data = fill;
        bus.mem_ready = 1'b1;
      end
      if (bus.ready) begin
        done = 1;
        bus.req_valid = 1'b0;
        if (exp_hit) check({nm, ".latency"}, cyc, 3);
        if (!wr) check({nm, ".rdata"}, bus.read_data, exp_rd);
      end
    end
    check({nm, ".ready"}, done, 1);
    check({nm, ".wb_seen"}, wb_seen, exp_wb);
    if (exp_hit) hits++;
    else misses++;
  endtask

  initial begin
    int cyc, r1, r2;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_read_data = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", bus.ready, 0);
    check("rst.hit", bus.l2_hit, 0);
    check("rst.rreq", bus.mem_read_req, 0);
    check("rst.wreq", bus.mem_write_req, 0);
    check("rst.rdata", bus.read_data, 0);
    check("rst.hitcnt", bus.hit_count, 0);
    check("rst.misscnt", bus.miss_count, 0);
    rst = 1'b1;
    // cold miss then hit; write hit makes A dirty
    access("cold_rd", 0, A, 0, 0, 0, 0, 0, A5, A5);
    access("rd_hit", 0, A, 0, 1, 0, 0, 0, 0, A5);
    access("wr_hit", 1, A, 128'h1111, 1, 0, 0, 0, 0, 0);
    // fill the remaining invalid ways of set 0x123
    access("fill_b", 0, B, 0, 0, 0, 0, 0, 128'hBBBB, 128'hBBBB);
    access("fill_c", 0, C, 0, 0, 0, 0, 0, 128'hCCCC, 128'hCCCC);
    access("fill_d", 0, D, 0, 0, 0, 0, 0, 128'hDDDD, 128'hDDDD);
    // set full, A is LRU and dirty: written back before E's fill
    access("evict_a", 0, E, 0, 0, 1, A, 128'h1111, 128'hEEEE, 128'hEEEE);
    // LRU now C,D,E,B after touching B: F evicts C, B survives
    access("touch_b", 0, B, 0, 1, 0, 0, 0, 0, 128'hBBBB);
    access("miss_f", 0, F, 0, 0, 0, 0, 0, 128'hFFFF, 128'hFFFF);
    access("b_kept", 0, B, 0, 1, 0, 0, 0, 0, 128'hBBBB);
    access("c_gone", 0, C, 0, 0, 0, 0, 0, 128'hC0C0, 128'hC0C0);
    // request held through ready: next acceptance one cycle after the ready cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr = B;
    cyc = 0;
    r1 = -1;
    r2 = -1;
    while (r2 < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.ready) begin
        if (r1 < 0) r1 = cyc;
        else r2 = cyc;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b.gap", r2 - r1, 4);
    hits += 2;
    // write miss: E is LRU and clean, line written with request data and marked dirty
    access("wr_miss", 1, G, 128'h7777, 0, 0, 0, 0, 128'h5555, 0);
    access("rd_g", 0, G, 0, 1, 0, 0, 0, 0, 128'h7777);
    check("cnt.hit", bus.hit_count, hits);
    check("cnt.miss", bus.miss_count, misses);
    // reset while FILL is waiting on memory
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr = H;
    cyc = 0;
    while (!bus.mem_read_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_fill.req", bus.mem_read_req, 1);
    rst = 1'b0;
    #1;
    check("rst_fill.rreq", bus.mem_read_req, 0);
    check("rst_fill.addr", bus.mem_addr, 0);
    check("rst_fill.miss", bus.l2_miss, 0);
    check("rst_fill.ready", bus.ready, 0);
    check("rst_fill.misscnt", bus.miss_count, 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    misses = 0;
    access("b_after_rst", 0, B, 0, 0, 0, 0, 0, 128'h9999, 128'h9999);
    // hit counter preloaded one below saturation
    force dut.hit_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_q;
    access("sat1", 0, B, 0, 1, 0, 0, 0, 0, 128'h9999);
    check("sat.first", bus.hit_count, 32'hFFFF_FFFF);
    access("sat2", 0, B, 0, 1, 0, 0, 0, 0, 128'h9999);
    check("sat.hold", bus.hit_count, 32'hFFFF_FFFF);
    check("sat.miss", bus.miss_count, misses);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
